// File: rtl/seven_segment_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-high, bit0 = segment a .. bit6 = segment g.
package seven_segment_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational digit-to-segment decoder, active-high segments.
// Values 10..15 show A,b,C,d,E,F only when hex_en_i is set, otherwise blank.
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [DIGIT_W-1:0] value_i,
  input  logic               blank_i,
  input  logic               hex_en_i,
  output logic [SEG_W-1:0]   seg_o
);

  // Blank overrides everything; hex letters are gated by hex_en_i.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (value_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = hex_en_i ? SEG_A : SEG_BLANK;
        4'hB: seg_o = hex_en_i ? SEG_B : SEG_BLANK;
        4'hC: seg_o = hex_en_i ? SEG_C : SEG_BLANK;
        4'hD: seg_o = hex_en_i ? SEG_D : SEG_BLANK;
        4'hE: seg_o = hex_en_i ? SEG_E : SEG_BLANK;
        4'hF: seg_o = hex_en_i ? SEG_F : SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 7-segment driver: latches a packed digit word on load and
// scans one digit per refresh slot, with leading-zero blanking and output
// polarity selection. Segments and digit select are registered outputs.
module seven_segment_scan
  import seven_segment_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1,
  parameter int HEX_EN      = 0,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DIGIT_W*DIGITS-1:0]   value_in,
  input  logic                        lzb_en,
  output logic [SEG_W-1:0]            segments,
  output logic [DIGITS-1:0]           digit_sel
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic              POL      = (ACTIVE_LOW != 0);
  localparam logic              HEX_BIT  = (HEX_EN != 0);
  // "Off" pattern doubles as the XOR mask that applies output polarity.
  localparam logic [SEG_W-1:0]  SEG_OFF  = {SEG_W{POL}};
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{POL}};

  logic [PRE_W-1:0]            pre_q, pre_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [DIGIT_W*DIGITS-1:0]   latch_q, latch_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic [DIGITS-1:0]           sel_q, sel_d;

  logic                        slot_end;
  logic [DIGIT_W-1:0]          digit_v [DIGITS];
  logic [DIGITS-1:0]           blank_v;
  logic                        zero_above;
  logic [DIGIT_W-1:0]          cur_digit;
  logic                        cur_blank;
  logic [DIGITS-1:0]           cur_sel;
  logic [SEG_W-1:0]            dec_seg;

  // Refresh prescaler and scan index: the index moves on the last prescaler count.
  always_comb begin
    slot_end = (pre_q == PRE_LAST);
    pre_d    = slot_end ? '0 : pre_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Display latch is written only by load; reset clears it in the register.
  always_comb begin
    latch_d = load ? value_in : latch_q;
  end

  // Split the latch into digits and build the leading-zero blank chain from the top.
  always_comb begin
    zero_above = 1'b1;
    blank_v    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit_v[k] = latch_q[k*DIGIT_W +: DIGIT_W];
    end
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (digit_v[k] == '0);
      // Digit 0 stays visible so an all-zero value still shows "0".
      blank_v[k] = lzb_en & zero_above & (k != 0);
    end
  end

  // Select the digit for the current slot and form its one-hot select.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    cur_sel   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit  = digit_v[k];
        cur_blank  = blank_v[k];
        cur_sel[k] = 1'b1;
      end
    end
  end

  seven_segment_decode u_decode (
    .value_i  (cur_digit),
    .blank_i  (cur_blank),
    .hex_en_i (HEX_BIT),
    .seg_o    (dec_seg)
  );

  // Apply output polarity ahead of the output registers.
  always_comb begin
    seg_d = dec_seg ^ SEG_OFF;
    sel_d = cur_sel ^ SEL_OFF;
  end

  // State and output registers; reset forces outputs to the "off" level.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      idx_q   <= '0;
      latch_q <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign segments  = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: two instances share stimulus.
//   A: DIGITS=4, REFRESH_DIV=1, HEX_EN=0, ACTIVE_LOW=0
//   B: DIGITS=4, REFRESH_DIV=3, HEX_EN=1, ACTIVE_LOW=1
module tb_seven_segment_scan;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value_in;
  logic        lzb_en;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  sel_a, sel_b;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [6:0] sa;
    logic [3:0] la;
    logic [6:0] sb;
    logic [3:0] lb;
  } exp_t;

  exp_t exp_q [$];

  // Reference state
  int          ia, ib, pb;
  logic [15:0] m_lat;

  seven_segment_scan #(.DIGITS(4), .REFRESH_DIV(1), .HEX_EN(0), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .lzb_en(lzb_en),
    .segments(seg_a), .digit_sel(sel_a)
  );

  seven_segment_scan #(.DIGITS(4), .REFRESH_DIV(3), .HEX_EN(1), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in), .lzb_en(lzb_en),
    .segments(seg_b), .digit_sel(sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int k,
                                         input bit lz, input bit hex);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = v >> (4 * k);
    d     = upper[3:0];
    if (lz && k > 0 && upper == 16'h0) return 7'h00;
    if (d > 4'd9 && !hex) return 7'h00;
    return TBL[d];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Check the shown digit against a per-digit pattern pack {d3,d2,d1,d0}.
  task automatic check_shown(input string tag, input logic [6:0] seg, input logic [3:0] sel,
                             input logic [27:0] pack, input bit inv);
    logic [6:0] s;
    logic [3:0] d;
    int idx;
    s   = inv ? ~seg : seg;
    d   = inv ? ~sel : sel;
    idx = -1;
    for (int i = 0; i < 4; i++) if (d == 4'(1 << i)) idx = i;
    check({tag, "_onehot"}, 8'($countones(d)), 8'd1);
    if (idx >= 0) check($sformatf("%s_d%0d", tag, idx), {1'b0, s}, {1'b0, pack[7*idx +: 7]});
  endtask

  // One clock: push expectation, clock, advance reference, pop and compare.
  task automatic step();
    exp_t e;
    if (reset) begin
      e.sa = 7'h00; e.la = 4'h0; e.sb = 7'h7F; e.lb = 4'hF;
    end else begin
      e.sa = ref_seg(m_lat, ia, lzb_en, 1'b0);
      e.la = 4'(1 << ia);
      e.sb = ~ref_seg(m_lat, ib, lzb_en, 1'b1);
      e.lb = ~4'(1 << ib);
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (reset) begin
      ia = 0; ib = 0; pb = 0; m_lat = 16'h0;
    end else begin
      if (load) m_lat = value_in;
      ia = (ia + 1) % 4;
      if (pb == 2) begin pb = 0; ib = (ib + 1) % 4; end
      else pb++;
    end
    #1;
    e = exp_q.pop_front();
    check("sb_segA", {1'b0, seg_a}, {1'b0, e.sa});
    check("sb_selA", {4'h0, sel_a}, {4'h0, e.la});
    check("sb_segB", {1'b0, seg_b}, {1'b0, e.sb});
    check("sb_selB", {4'h0, sel_b}, {4'h0, e.lb});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value_in = 16'h0; lzb_en = 1'b0;
    ia = 0; ib = 0; pb = 0; m_lat = 16'h0;
    @(negedge clk);

    repeat (3) step();
    check("rst_segA", {1'b0, seg_a}, 8'h00);
    check("rst_selA", {4'h0, sel_a}, 8'h00);
    check("rst_segB", {1'b0, seg_b}, 8'h7F);
    check("rst_selB", {4'h0, sel_b}, 8'h0F);

    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("walkA%0d", i), {4'h0, sel_a}, {4'h0, 4'(1 << (i % 4))});
      check($sformatf("walkB%0d", i), {4'h0, sel_b}, {4'h0, ~4'(1 << (i / 3))});
      check($sformatf("zeroB%0d", i), {1'b0, seg_b}, 8'h40);
    end

    value_in = 16'h1234; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin
      step();
      check_shown("v1234", seg_a, sel_a, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0);
    end

    lzb_en = 1'b1;
    value_in = 16'h0070; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin
      step();
      check_shown("lzb0070", seg_a, sel_a, {7'h00, 7'h00, 7'h07, 7'h3F}, 1'b0);
    end

    value_in = 16'h0000; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin
      step();
      check_shown("lzb0000", seg_a, sel_a, {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0);
    end

    lzb_en = 1'b0;
    value_in = 16'h000A; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin
      step();
      check_shown("hexA_off", seg_a, sel_a, {7'h3F, 7'h3F, 7'h3F, 7'h00}, 1'b0);
      check_shown("hexA_on", seg_b, sel_b, {7'h3F, 7'h3F, 7'h3F, 7'h77}, 1'b1);
    end

    value_in = 16'h8888; load = 1'b1; step(); load = 1'b0;
    repeat (6) begin
      step();
      check("eight_rawB", {1'b0, seg_b}, 8'h00);
      check_shown("eightA", seg_a, sel_a, {4{7'h7F}}, 1'b0);
    end

    value_in = 16'h5678; load = 1'b1; step(); load = 1'b0;
    repeat (4) begin
      step();
      check_shown("v5678A", seg_a, sel_a, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 1'b0);
      check_shown("v5678B", seg_b, sel_b, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 1'b1);
    end

    step();
    reset = 1'b1; step();
    check("midrst_segA", {1'b0, seg_a}, 8'h00);
    check("midrst_selA", {4'h0, sel_a}, 8'h00);
    check("midrst_segB", {1'b0, seg_b}, 8'h7F);
    check("midrst_selB", {4'h0, sel_b}, 8'h0F);
    reset = 1'b0; step();
    check("restart_selA", {4'h0, sel_a}, 8'h01);
    check("restart_selB", {4'h0, sel_b}, 8'h0E);
    check("restart_segA", {1'b0, seg_a}, 8'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
